mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-ported unified memory between instruction fetch and data load/store in the single-cycle core.
- Replaces the split IAD/DAD memory ports with one port.
- Issues one access at a time and waits a fixed memory latency.
- Returns read data with a valid pulse.
- The core's stall logic gates pc_enable and register write on the valid pulses.

---
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// One access at a time, fixed MEM_LATENCY, fair alternation on ties; all outputs registered.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic SEL_IF = 1'b0;
    localparam logic SEL_D  = 1'b1;

    state_t     state, state_nxt;
    logic       last_grant, grant_nxt;
    logic       take;
    logic       cur_we;
    logic [3:0] cnt;

    // last_grant doubles as the owner of the access in flight.
    always_comb begin
        state_nxt = state;
        grant_nxt = last_grant;
        take      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (if_req && d_req) begin
                    take      = 1'b1;
                    grant_nxt = ~last_grant;
                end else if (if_req) begin
                    take      = 1'b1;
                    grant_nxt = SEL_IF;
                end else if (d_req) begin
                    take      = 1'b1;
                    grant_nxt = SEL_D;
                end
                state_nxt = take ? ISSUE : IDLE;
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (cnt == 4'd1) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= SEL_D;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
        end
    end

    // Outputs are computed one cycle ahead from the next state so they come straight off flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            cur_we    <= 1'b0;
            cnt       <= '0;
        end else begin
            if_gnt   <= take && (grant_nxt == SEL_IF);
            d_gnt    <= take && (grant_nxt == SEL_D);
            mem_en   <= take;
            mem_we   <= take && (grant_nxt == SEL_D) && d_we;
            busy     <= (state_nxt == ISSUE) || (state_nxt == WAIT);
            if_valid <= (state == WAIT) && (state_nxt == DONE) && (last_grant == SEL_IF);
            d_valid  <= (state == WAIT) && (state_nxt == DONE) && (last_grant == SEL_D);

            if (take) begin
                cur_we <= (grant_nxt == SEL_D) && d_we;
                if (grant_nxt == SEL_IF) begin
                    mem_addr <= if_addr;
                end else begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end
            end

            if (state == ISSUE)
                cnt <= 4'(MEM_LATENCY);
            else if (state == WAIT)
                cnt <= cnt - 4'd1;

            // Read data is sampled on the edge that closes the last WAIT cycle.
            if ((state == WAIT) && (cnt == 4'd1)) begin
                if (last_grant == SEL_IF)
                    if_rdata <= mem_rdata;
                else if (!cur_we)
                    d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at latency 2, one at latency 1,
// each backed by a small latency-accurate memory model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata;

    logic          if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          l1_if_gnt, l1_if_valid, l1_d_gnt, l1_d_valid, l1_mem_en, l1_mem_we, l1_busy;
    logic [DW-1:0] l1_if_rdata, l1_d_rdata, l1_mem_wdata, l1_mem_rdata;
    logic [AW-1:0] l1_mem_addr;

    mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(AW), .DATA_W(DW)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(l1_if_gnt), .if_valid(l1_if_valid), .if_rdata(l1_if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(l1_d_gnt), .d_valid(l1_d_valid), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    // Word memory; only the latency-2 instance writes it.
    logic [31:0] ram [0:1023];
    logic [31:0] pipe0, pipe1, l1_pipe;

    always @(posedge clk) begin
        if (rst) begin
            ram[0]  <= 32'h0;
            ram[1]  <= 32'h12345678;
            ram[64] <= 32'h00500093;
        end else if (mem_en && mem_we) begin
            ram[mem_addr[11:2]] <= mem_wdata;
        end
        pipe0   <= (mem_en && !mem_we) ? ram[mem_addr[11:2]] : JUNK;
        pipe1   <= pipe0;
        l1_pipe <= (l1_mem_en && !l1_mem_we) ? ram[l1_mem_addr[11:2]] : JUNK;
    end
    assign mem_rdata    = pipe1;
    assign l1_mem_rdata = l1_pipe;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] if_q [$];
    logic [31:0] d_q  [$];
    int          gnt_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
    endtask

    task automatic apply_reset();
        drop_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Steps until the selected valid pulses; n = steps taken, -1 on timeout.
    task automatic wait_valid(input int which, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if ((which == 0 && if_valid) || (which == 1 && d_valid) || (which == 2 && l1_d_valid)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [6:0] strobes;
        drop_all();
        if_addr = '0; d_addr = '0; d_wdata = '0;
        rst = 1'b1;
        step();
        strobes = {if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy};
        n_checks++;
        if (strobes !== 7'b0) begin n_fail++; $display("FAIL reset_strobes: got %b expected 0000000", strobes); end
        n_checks++;
        if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got if=%h d=%h expected 0", if_rdata, d_rdata);
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        int n;
        logic [31:0] exp;
        if_addr = 32'h100;
        if_req  = 1'b1;
        step();
        n_checks++;
        if (!(if_gnt === 1'b1 && d_gnt === 1'b0 && mem_en === 1'b1 && mem_we === 1'b0 && busy === 1'b1)) begin
            n_fail++; $display("FAIL fetch_issue: got gnt=%b dgnt=%b en=%b we=%b busy=%b expected 1 0 1 0 1",
                               if_gnt, d_gnt, mem_en, mem_we, busy);
        end
        n_checks++;
        if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch_addr: got %h expected 00000100", mem_addr); end
        if_q.push_back(32'h00500093);
        if_req = 1'b0;
        step();
        n_checks++;
        if (!(busy === 1'b1 && mem_en === 1'b0 && if_gnt === 1'b0)) begin
            n_fail++; $display("FAIL fetch_wait: got busy=%b en=%b gnt=%b expected 1 0 0", busy, mem_en, if_gnt);
        end
        step();
        n_checks++;
        if (!(busy === 1'b1 && if_valid === 1'b0)) begin
            n_fail++; $display("FAIL fetch_wait2: got busy=%b valid=%b expected 1 0", busy, if_valid);
        end
        wait_valid(0, n);
        n_checks++;
        if (n != 1) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 1 more cycle", n); end
        exp = if_q.pop_front();
        n_checks++;
        if (if_rdata !== exp || busy !== 1'b0) begin
            n_fail++; $display("FAIL fetch_data: got %h busy=%b expected %h busy=0", if_rdata, busy, exp);
        end
        step();
        n_checks++;
        if (if_valid !== 1'b0 || if_rdata !== exp) begin
            n_fail++; $display("FAIL fetch_hold: got valid=%b data=%h expected 0 %h", if_valid, if_rdata, exp);
        end
    endtask

    task automatic test_reset_in_wait();
        int seen;
        if_addr = 32'h100;
        if_req  = 1'b1;
        step();
        n_checks++;
        if (if_gnt !== 1'b1) begin n_fail++; $display("FAIL rstwait_gnt: got %b expected 1", if_gnt); end
        if_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy} !== 7'b0 ||
            if_rdata !== 32'h0 || d_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rstwait_clear: got busy=%b if_rdata=%h mem_addr=%h expected all 0",
                               busy, if_rdata, mem_addr);
        end
        step();
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (if_valid === 1'b1 || busy === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rstwait_no_valid: got %0d active cycles expected 0", seen); end
        if_addr = 32'h100; d_addr = 32'h2004;
        if_req = 1'b1; d_req = 1'b1;
        step();
        n_checks++;
        if (!(if_gnt === 1'b1 && d_gnt === 1'b0)) begin
            n_fail++; $display("FAIL rstwait_tie_first: got if_gnt=%b d_gnt=%b expected 1 0", if_gnt, d_gnt);
        end
        drop_all();
        repeat (8) step();
    endtask

    task automatic test_tie();
        int cyc, last_g, exp_g, errs;
        logic [31:0] exp;
        apply_reset();
        if_addr = 32'h100; d_addr = 32'h2004; d_we = 1'b0;
        gnt_q = '{0, 1, 0, 1};
        if_req = 1'b1; d_req = 1'b1;
        last_g = -1;
        errs = 0;
        for (cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (if_valid && d_valid) errs++;
            if ((if_gnt && if_valid) || (d_gnt && d_valid)) errs++;
            if (mem_en) begin
                exp_g = (gnt_q.size() != 0) ? gnt_q.pop_front() : -1;
                n_checks++;
                if (!((exp_g == 0 && if_gnt && !d_gnt) || (exp_g == 1 && d_gnt && !if_gnt))) begin
                    n_fail++; $display("FAIL tie_order: got if_gnt=%b d_gnt=%b expected grant %0d", if_gnt, d_gnt, exp_g);
                end
                if (last_g >= 0) begin
                    n_checks++;
                    if (cyc - last_g != 4) begin
                        n_fail++; $display("FAIL tie_period: got %0d expected 4", cyc - last_g);
                    end
                end
                last_g = cyc;
                if (exp_g == 0) if_q.push_back(32'h00500093);
                else d_q.push_back(32'h12345678);
                if (gnt_q.size() == 0) drop_all();
            end
            if (if_valid) begin
                exp = if_q.pop_front();
                n_checks++;
                if (if_rdata !== exp) begin n_fail++; $display("FAIL tie_if_data: got %h expected %h", if_rdata, exp); end
            end
            if (d_valid) begin
                exp = d_q.pop_front();
                n_checks++;
                if (d_rdata !== exp) begin n_fail++; $display("FAIL tie_d_data: got %h expected %h", d_rdata, exp); end
            end
            if (gnt_q.size() == 0 && if_q.size() == 0 && d_q.size() == 0) break;
        end
        n_checks++;
        if (gnt_q.size() != 0 || if_q.size() != 0 || d_q.size() != 0 || errs != 0) begin
            n_fail++; $display("FAIL tie_complete: got pending=%0d overlap=%0d expected 0 0",
                               gnt_q.size() + if_q.size() + d_q.size(), errs);
        end
        drop_all();
        repeat (3) step();
    endtask

    task automatic test_store();
        int n;
        logic [31:0] exp;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        d_q.push_back(32'h12345678);
        step();
        n_checks++;
        if (!(d_gnt === 1'b1 && mem_en === 1'b1 && mem_we === 1'b1 &&
              mem_addr === 32'h2000 && mem_wdata === 32'hDEADBEEF)) begin
            n_fail++; $display("FAIL store_issue: got gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 00002000 deadbeef",
                               d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        drop_all();
        step();
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL store_we_drop: got %b expected 0", mem_we); end
        wait_valid(1, n);
        n_checks++;
        if (n != 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2 more cycles", n); end
        exp = d_q.pop_front();
        n_checks++;
        if (d_rdata !== exp) begin n_fail++; $display("FAIL store_rdata_hold: got %h expected %h", d_rdata, exp); end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] exp;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        step();
        n_checks++;
        if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1: got %b expected 1", d_gnt); end
        d_q.push_back(32'hDEADBEEF);
        wait_valid(1, n);
        n_checks++;
        if (n != 3) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected 3", n); end
        exp = d_q.pop_front();
        n_checks++;
        if (d_rdata !== exp) begin n_fail++; $display("FAIL b2b_data1: got %h expected %h", d_rdata, exp); end
        step();
        n_checks++;
        if (!(d_gnt === 1'b1 && mem_en === 1'b1 && d_valid === 1'b0)) begin
            n_fail++; $display("FAIL b2b_gnt2: got gnt=%b en=%b valid=%b expected 1 1 0", d_gnt, mem_en, d_valid);
        end
        d_q.push_back(32'hDEADBEEF);
        drop_all();
        wait_valid(1, n);
        n_checks++;
        if (n != 3) begin n_fail++; $display("FAIL b2b_latency2: got %0d expected 3", n); end
        exp = d_q.pop_front();
        n_checks++;
        if (d_rdata !== exp) begin n_fail++; $display("FAIL b2b_data2: got %h expected %h", d_rdata, exp); end
        step();
    endtask

    task automatic test_load_l1();
        int n;
        logic [31:0] exp;
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2004;
        step();
        n_checks++;
        if (!(l1_d_gnt === 1'b1 && l1_mem_en === 1'b1 && l1_mem_addr === 32'h2004)) begin
            n_fail++; $display("FAIL l1_issue: got gnt=%b en=%b addr=%h expected 1 1 00002004",
                               l1_d_gnt, l1_mem_en, l1_mem_addr);
        end
        d_q.push_back(32'h12345678);
        drop_all();
        wait_valid(2, n);
        n_checks++;
        if (n != 2) begin n_fail++; $display("FAIL l1_latency: got %0d expected 2", n); end
        exp = d_q.pop_front();
        n_checks++;
        if (l1_d_rdata !== exp || l1_busy !== 1'b0) begin
            n_fail++; $display("FAIL l1_data: got %h busy=%b expected %h busy=0", l1_d_rdata, l1_busy, exp);
        end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_reset_in_wait();
        test_tie();
        test_store();
        test_back_to_back();
        test_load_l1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
